// File: rtl/ctrl_pkg.sv
// Shared encodings for the pipelined MIPS controller: opcode/func maps, ALU codes,
// select encodings, the control-bundle struct and the register-usage helper.
package ctrl_pkg;

    localparam int MUL_CNT_W   = 4;
    localparam int FLUSH_CNT_W = 2;

    localparam logic [5:0] OP_SPECIAL  = 6'b000000;
    localparam logic [5:0] OP_REGIMM   = 6'b000001;
    localparam logic [5:0] OP_J        = 6'b000010;
    localparam logic [5:0] OP_JAL      = 6'b000011;
    localparam logic [5:0] OP_BEQ      = 6'b000100;
    localparam logic [5:0] OP_BNE      = 6'b000101;
    localparam logic [5:0] OP_BLEZ     = 6'b000110;
    localparam logic [5:0] OP_BGTZ     = 6'b000111;
    localparam logic [5:0] OP_ADDI     = 6'b001000;
    localparam logic [5:0] OP_ADDIU    = 6'b001001;
    localparam logic [5:0] OP_SLTI     = 6'b001010;
    localparam logic [5:0] OP_SLTIU    = 6'b001011;
    localparam logic [5:0] OP_ANDI     = 6'b001100;
    localparam logic [5:0] OP_ORI      = 6'b001101;
    localparam logic [5:0] OP_XORI     = 6'b001110;
    localparam logic [5:0] OP_LUI      = 6'b001111;
    localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
    localparam logic [5:0] OP_LB       = 6'b100000;
    localparam logic [5:0] OP_LH       = 6'b100001;
    localparam logic [5:0] OP_LW       = 6'b100011;
    localparam logic [5:0] OP_SB       = 6'b101000;
    localparam logic [5:0] OP_SH       = 6'b101001;
    localparam logic [5:0] OP_SW       = 6'b101011;

    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_SRA   = 6'b000011;
    localparam logic [5:0] F_SLLV  = 6'b000100;
    localparam logic [5:0] F_SRLV  = 6'b000110;
    localparam logic [5:0] F_SRAV  = 6'b000111;
    localparam logic [5:0] F_JR    = 6'b001000;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;

    // SPECIAL2 function codes
    localparam logic [5:0] F2_MADD = 6'b000000;
    localparam logic [5:0] F2_MUL  = 6'b000010;
    localparam logic [5:0] F2_MSUB = 6'b000100;

    typedef enum logic [4:0] {
        ALU_ADD   = 5'b00000, ALU_ADDU  = 5'b00001, ALU_SUB  = 5'b00010, ALU_SUBU = 5'b00011,
        ALU_AND   = 5'b00100, ALU_OR    = 5'b00101, ALU_XOR  = 5'b00110, ALU_NOR  = 5'b00111,
        ALU_SLT   = 5'b01000, ALU_SLTU  = 5'b01001, ALU_SLL  = 5'b01010, ALU_SRL  = 5'b01011,
        ALU_SRA   = 5'b01100, ALU_LUI   = 5'b01101, ALU_MULT = 5'b01110, ALU_MULTU = 5'b01111,
        ALU_MADD  = 5'b10000, ALU_MSUB  = 5'b10001, ALU_MUL  = 5'b10010, ALU_MTHI = 5'b10011,
        ALU_MTLO  = 5'b10100, ALU_MFLO  = 5'b10101, ALU_MFHI = 5'b10110
    } alu_op_e;

    typedef enum logic [2:0] {
        BR_EQ = 3'b000, BR_NE = 3'b001, BR_LEZ = 3'b010, BR_GTZ = 3'b011,
        BR_LTZ = 3'b100, BR_GEZ = 3'b101, BR_ALWAYS = 3'b110
    } br_res_e;

    typedef enum logic [1:0] {DM_WORD = 2'd0, DM_HALF = 2'd1, DM_BYTE = 2'd2} dm_sel_e;
    typedef enum logic [1:0] {J_NONE = 2'd0, J_ABS = 2'd1, J_REG = 2'd2} jsel_e;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_MULBUSY = 2'd1, ST_FLUSH = 2'd2} state_e;

    typedef struct packed {
        logic    alu_src;
        logic    reg_dst;
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    mem_to_reg;   // 1 selects the ALU result, 0 the load data
        logic    branch;
        logic    shift_op;
        logic    hi_write;
        logic    lo_write;
        logic    imm_unsign;
        logic    branch_sel;
        logic    cont_flush;
        logic    illegal;
        alu_op_e alu_op;
        br_res_e br_res;
        dm_sel_e dm_sel;
        jsel_e   jsel;
    } ctrl_bundle_t;

    typedef struct packed {
        logic rs;
        logic rt;
    } reg_use_t;

    localparam ctrl_bundle_t BUBBLE = '0;

    // Which GPR source fields a legal encoding actually reads.
    function automatic reg_use_t reg_use(input logic [5:0] op, input logic [5:0] funct);
        reg_use_t u;
        u = '0;
        case (op)
            OP_SPECIAL: begin
                case (funct)
                    F_SLL, F_SRL, F_SRA:   u.rt = 1'b1;
                    F_MFHI, F_MFLO:        u = '0;
                    F_JR, F_MTHI, F_MTLO:  u.rs = 1'b1;
                    default:               u = '{rs: 1'b1, rt: 1'b1};
                endcase
            end
            OP_SPECIAL2, OP_BEQ, OP_BNE, OP_SB, OP_SH, OP_SW: u = '{rs: 1'b1, rt: 1'b1};
            OP_J, OP_JAL, OP_LUI:                             u = '0;
            default:                                          u.rs = 1'b1;
        endcase
        return u;
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational opcode/func -> control-bundle map with the register-usage,
// HI/LO-usage and multiply-class flags the hazard logic needs.
module instr_decoder
    import ctrl_pkg::*;
(
    input  logic [5:0]   op,
    input  logic [5:0]   funct,
    input  logic [4:0]   shamt,
    input  logic [4:0]   rt,
    input  logic         valid,
    output ctrl_bundle_t bundle,
    output logic         reads_rs,
    output logic         reads_rt,
    output logic         uses_hilo,
    output logic         is_mult,
    output logic         is_mul_gpr
);

    ctrl_bundle_t dec;
    reg_use_t     usage;
    logic         legal;
    logic         hilo;
    logic         mult;
    logic         mul_gpr;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path infers a latch.
        dec     = BUBBLE;
        legal   = 1'b1;
        hilo    = 1'b0;
        mult    = 1'b0;
        mul_gpr = 1'b0;
        case (op)
            OP_SPECIAL: begin
                dec.reg_dst    = 1'b1;
                dec.reg_write  = 1'b1;
                dec.mem_to_reg = 1'b1;
                case (funct)
                    F_ADD:  dec.alu_op = ALU_ADD;
                    F_ADDU: dec.alu_op = ALU_ADDU;
                    F_SUB:  dec.alu_op = ALU_SUB;
                    F_SUBU: dec.alu_op = ALU_SUBU;
                    F_AND:  dec.alu_op = ALU_AND;
                    F_OR:   dec.alu_op = ALU_OR;
                    F_XOR:  dec.alu_op = ALU_XOR;
                    F_NOR:  dec.alu_op = ALU_NOR;
                    F_SLT:  dec.alu_op = ALU_SLT;
                    F_SLTU: dec.alu_op = ALU_SLTU;
                    F_SLL:  begin dec.alu_op = ALU_SLL; dec.shift_op = 1'b1; end
                    F_SRL:  begin dec.alu_op = ALU_SRL; dec.shift_op = 1'b1; end
                    F_SRA:  begin dec.alu_op = ALU_SRA; dec.shift_op = 1'b1; end
                    F_SLLV: dec.alu_op = ALU_SLL;
                    F_SRLV: dec.alu_op = ALU_SRL;
                    F_SRAV: dec.alu_op = ALU_SRA;
                    F_MFHI: begin dec.alu_op = ALU_MFHI; hilo = 1'b1; end
                    F_MFLO: begin dec.alu_op = ALU_MFLO; hilo = 1'b1; end
                    F_JR: begin
                        dec            = BUBBLE;
                        dec.branch     = 1'b1;
                        dec.branch_sel = 1'b1;
                        dec.br_res     = BR_ALWAYS;
                        dec.jsel       = J_REG;
                    end
                    F_MTHI: begin
                        dec          = BUBBLE;
                        dec.hi_write = 1'b1;
                        dec.alu_op   = ALU_MTHI;
                        hilo         = 1'b1;
                    end
                    F_MTLO: begin
                        dec          = BUBBLE;
                        dec.lo_write = 1'b1;
                        dec.alu_op   = ALU_MTLO;
                        hilo         = 1'b1;
                    end
                    F_MULT, F_MULTU: begin
                        dec          = BUBBLE;
                        dec.hi_write = 1'b1;
                        dec.lo_write = 1'b1;
                        dec.alu_op   = (funct == F_MULT) ? ALU_MULT : ALU_MULTU;
                        hilo         = 1'b1;
                        mult         = 1'b1;
                    end
                    default: legal = 1'b0;
                endcase
                // Only the immediate shifts may carry a non-zero shamt field.
                if (shamt != '0 && !(funct inside {F_SLL, F_SRL, F_SRA})) legal = 1'b0;
            end
            OP_SPECIAL2: begin
                hilo = 1'b1;
                mult = 1'b1;
                case (funct)
                    F2_MADD: begin dec.hi_write = 1'b1; dec.lo_write = 1'b1; dec.alu_op = ALU_MADD; end
                    F2_MSUB: begin dec.hi_write = 1'b1; dec.lo_write = 1'b1; dec.alu_op = ALU_MSUB; end
                    F2_MUL: begin
                        dec.reg_dst    = 1'b1;
                        dec.reg_write  = 1'b1;
                        dec.mem_to_reg = 1'b1;
                        dec.alu_op     = ALU_MUL;
                        mul_gpr        = 1'b1;
                    end
                    default: legal = 1'b0;
                endcase
                if (shamt != '0) legal = 1'b0;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                dec.alu_src    = 1'b1;
                dec.reg_write  = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.imm_unsign = op inside {OP_ANDI, OP_ORI, OP_XORI};
                case (op)
                    OP_ADDI:  dec.alu_op = ALU_ADD;
                    OP_ADDIU: dec.alu_op = ALU_ADDU;
                    OP_SLTI:  dec.alu_op = ALU_SLT;
                    OP_SLTIU: dec.alu_op = ALU_SLTU;
                    OP_ANDI:  dec.alu_op = ALU_AND;
                    OP_ORI:   dec.alu_op = ALU_OR;
                    OP_XORI:  dec.alu_op = ALU_XOR;
                    default:  dec.alu_op = ALU_LUI;
                endcase
            end
            OP_LW, OP_LH, OP_LB: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.mem_read  = 1'b1;
                dec.alu_op    = ALU_ADD;
                dec.dm_sel    = (op == OP_LW) ? DM_WORD : ((op == OP_LH) ? DM_HALF : DM_BYTE);
            end
            OP_SW, OP_SH, OP_SB: begin
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
                dec.alu_op    = ALU_ADD;
                dec.dm_sel    = (op == OP_SW) ? DM_WORD : ((op == OP_SH) ? DM_HALF : DM_BYTE);
            end
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
                dec.branch = 1'b1;
                dec.alu_op = ALU_SUB;
                case (op)
                    OP_BEQ:  dec.br_res = BR_EQ;
                    OP_BNE:  dec.br_res = BR_NE;
                    OP_BLEZ: dec.br_res = BR_LEZ;
                    default: dec.br_res = BR_GTZ;
                endcase
            end
            OP_REGIMM: begin
                dec.branch = 1'b1;
                dec.alu_op = ALU_SUB;
                if (rt == 5'd0)      dec.br_res = BR_LTZ;
                else if (rt == 5'd1) dec.br_res = BR_GEZ;
                else                 legal = 1'b0;
            end
            OP_J, OP_JAL: begin
                dec.branch     = 1'b1;
                dec.branch_sel = 1'b1;
                dec.br_res     = BR_ALWAYS;
                dec.jsel       = J_ABS;
                dec.reg_write  = (op == OP_JAL);
            end
            default: legal = 1'b0;
        endcase

        if (!valid || !legal) begin
            dec     = BUBBLE;
            hilo    = 1'b0;
            mult    = 1'b0;
            mul_gpr = 1'b0;
        end
        dec.illegal = valid && !legal;
        usage = (valid && legal) ? reg_use(op, funct) : '0;
    end

    assign bundle     = dec;
    assign reads_rs   = usage.rs;
    assign reads_rt   = usage.rt;
    assign uses_hilo  = hilo;
    assign is_mult    = mult;
    assign is_mul_gpr = mul_gpr;

endmodule

// File: rtl/pipelined_controller.sv
// ID-stage controller: registers the decoded bundle into ID/EX and generates the
// load-use stall, taken-branch flush bubbles and the HI/LO multiply interlock.
module pipelined_controller
    import ctrl_pkg::*;
#(
    parameter int MUL_LAT      = 4,
    parameter int FLUSH_CYCLES = 1,
    parameter int ALUOP_W      = 5
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic [31:0]        Instr,
    input  logic               InstrValid,
    input  logic               BranchTaken,
    input  logic               ExMemRead,
    input  logic [4:0]         ExRt,
    output logic               Stall,
    output logic               ALUSrc,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               MemtoReg,
    output logic               Branch,
    output logic               ShiftOp,
    output logic               Hi_write,
    output logic               Lo_write,
    output logic               immUnsign,
    output logic               branchSel,
    output logic               ContFlush,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [2:0]         branchRes,
    output logic [1:0]         DM_Sel,
    output logic [1:0]         JSel,
    output logic               MulBusy,
    output logic               IllegalOp
);

    logic [4:0] rs, rt, rd;
    assign rs = Instr[25:21];
    assign rt = Instr[20:16];
    assign rd = Instr[15:11];

    ctrl_bundle_t dec_bundle, bundle_d, bundle_q;
    logic         reads_rs, reads_rt, uses_hilo, is_mult, is_mul_gpr;

    instr_decoder u_decoder (
        .op         (Instr[31:26]),
        .funct      (Instr[5:0]),
        .shamt      (Instr[10:6]),
        .rt         (rt),
        .valid      (InstrValid),
        .bundle     (dec_bundle),
        .reads_rs   (reads_rs),
        .reads_rt   (reads_rt),
        .uses_hilo  (uses_hilo),
        .is_mult    (is_mult),
        .is_mul_gpr (is_mul_gpr)
    );

    state_e                 state_q, state_d;
    logic [MUL_CNT_W-1:0]   mul_cnt_q, mul_cnt_d;
    logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [4:0]             mul_rd_q;
    logic                   mul_gpr_q;
    logic                   flush_active, mul_window, load_use, hilo_stall, mul_dep;
    logic                   stall, issue_mult;

    always_comb begin
        flush_active = BranchTaken || (state_q == ST_FLUSH && flush_cnt_q != '0);
        // Result is ready on the edge the counter leaves 1, so a consumer can latch then.
        mul_window   = mul_cnt_q > MUL_CNT_W'(1);
        load_use     = ExMemRead && ExRt != '0 &&
                       ((reads_rs && rs == ExRt) || (reads_rt && rt == ExRt));
        hilo_stall   = uses_hilo && mul_window;
        mul_dep      = mul_window && mul_gpr_q && mul_rd_q != '0 &&
                       ((reads_rs && rs == mul_rd_q) || (reads_rt && rt == mul_rd_q));
        stall        = !flush_active && (load_use || hilo_stall || mul_dep);
        issue_mult   = is_mult && !flush_active && !stall;

        mul_cnt_d = '0;
        if (issue_mult)             mul_cnt_d = MUL_CNT_W'(MUL_LAT);
        else if (mul_cnt_q != '0)   mul_cnt_d = mul_cnt_q - MUL_CNT_W'(1);

        flush_cnt_d = '0;
        if (BranchTaken)            flush_cnt_d = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
        else if (flush_cnt_q != '0) flush_cnt_d = flush_cnt_q - FLUSH_CNT_W'(1);

        bundle_d = dec_bundle;
        if (flush_active) begin
            bundle_d            = BUBBLE;
            bundle_d.cont_flush = 1'b1;
        end else if (stall) begin
            bundle_d = BUBBLE;
        end
    end

    // FLUSH lasts exactly as long as flush bubbles are being loaded.
    always_comb begin
        state_d = state_q;
        if (BranchTaken) begin
            state_d = ST_FLUSH;
        end else begin
            case (state_q)
                ST_FLUSH: if (flush_cnt_q == '0) state_d = (mul_cnt_d != '0) ? ST_MULBUSY : ST_IDLE;
                default:  state_d = (mul_cnt_d != '0) ? ST_MULBUSY : ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            bundle_q    <= BUBBLE;
            mul_cnt_q   <= '0;
            flush_cnt_q <= '0;
            mul_rd_q    <= '0;
            mul_gpr_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            bundle_q    <= bundle_d;
            mul_cnt_q   <= mul_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            if (issue_mult) begin
                mul_rd_q  <= rd;
                mul_gpr_q <= is_mul_gpr;
            end
        end
    end

    assign Stall     = stall;
    assign MulBusy   = mul_cnt_q != '0;
    assign ALUSrc    = bundle_q.alu_src;
    assign RegDst    = bundle_q.reg_dst;
    assign RegWrite  = bundle_q.reg_write;
    assign MemRead   = bundle_q.mem_read;
    assign MemWrite  = bundle_q.mem_write;
    assign MemtoReg  = bundle_q.mem_to_reg;
    assign Branch    = bundle_q.branch;
    assign ShiftOp   = bundle_q.shift_op;
    assign Hi_write  = bundle_q.hi_write;
    assign Lo_write  = bundle_q.lo_write;
    assign immUnsign = bundle_q.imm_unsign;
    assign branchSel = bundle_q.branch_sel;
    assign ContFlush = bundle_q.cont_flush;
    assign IllegalOp = bundle_q.illegal;
    assign ALUOp     = ALUOP_W'(bundle_q.alu_op);
    assign branchRes = bundle_q.br_res;
    assign DM_Sel    = bundle_q.dm_sel;
    assign JSel      = bundle_q.jsel;

endmodule

// File: tb/tb_pipelined_controller.sv
// Directed bench for pipelined_controller (MUL_LAT=4, FLUSH_CYCLES=2) with hand-computed
// expectations for decode, load-use, multiply interlock, flush and reset behaviour.
module tb_pipelined_controller;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic [31:0] Instr = '0;
    logic        InstrValid = 1'b0, BranchTaken = 1'b0, ExMemRead = 1'b0;
    logic [4:0]  ExRt = '0;
    logic        Stall, ALUSrc, RegDst, RegWrite, MemRead, MemWrite, MemtoReg, Branch, ShiftOp;
    logic        Hi_write, Lo_write, immUnsign, branchSel, ContFlush, MulBusy, IllegalOp;
    logic [4:0]  ALUOp;
    logic [2:0]  branchRes;
    logic [1:0]  DM_Sel, JSel;

    int total = 0;
    int bad   = 0;

    pipelined_controller #(.MUL_LAT(4), .FLUSH_CYCLES(2), .ALUOP_W(5)) dut (
        .Clk(Clk), .Rst(Rst), .Instr(Instr), .InstrValid(InstrValid), .BranchTaken(BranchTaken),
        .ExMemRead(ExMemRead), .ExRt(ExRt), .Stall(Stall), .ALUSrc(ALUSrc), .RegDst(RegDst),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .Branch(Branch), .ShiftOp(ShiftOp), .Hi_write(Hi_write), .Lo_write(Lo_write),
        .immUnsign(immUnsign), .branchSel(branchSel), .ContFlush(ContFlush), .ALUOp(ALUOp),
        .branchRes(branchRes), .DM_Sel(DM_Sel), .JSel(JSel), .MulBusy(MulBusy), .IllegalOp(IllegalOp)
    );

    always #5 Clk = ~Clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Every registered bundle output; IllegalOp sits at bit 12, ContFlush at bit 13.
    function automatic logic [31:0] all_ctrl();
        return {6'b0, ALUSrc, RegDst, RegWrite, MemRead, MemWrite, MemtoReg, Branch, ShiftOp,
                Hi_write, Lo_write, immUnsign, branchSel, ContFlush, IllegalOp,
                ALUOp, branchRes, DM_Sel, JSel};
    endfunction

    function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, 5'b00000, fn};
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic vld);
        Instr      = ins;
        InstrValid = vld;
        #1;
    endtask

    logic [31:0] add_3_1_2, add_6_5_7, mult_1_2, mflo_4, mul_5_1_2, sw_2_1, jal_ins, ill_ins, lb_2_1;

    initial begin
        add_3_1_2 = r_ins(5'd1, 5'd2, 5'd3, 6'b100000);
        add_6_5_7 = r_ins(5'd5, 5'd7, 5'd6, 6'b100000);
        mult_1_2  = r_ins(5'd1, 5'd2, 5'd0, 6'b011000);
        mflo_4    = r_ins(5'd0, 5'd0, 5'd4, 6'b010010);
        mul_5_1_2 = {6'b011100, 5'd1, 5'd2, 5'd5, 5'd0, 6'b000010};
        sw_2_1    = {6'b101011, 5'd1, 5'd2, 16'h0000};
        lb_2_1    = {6'b100000, 5'd1, 5'd2, 16'h0004};
        jal_ins   = {6'b000011, 26'h0000040};
        ill_ins   = {6'b111111, 26'h0000000};

        // Reset state
        #12;
        check("reset_ctrl", all_ctrl(), 32'h0);
        check("reset_mulbusy", {31'b0, MulBusy}, 32'h0);
        @(negedge Clk);
        Rst = 1'b1;

        // add $3,$1,$2
        drive(add_3_1_2, 1'b1);
        check("add_nostall", {31'b0, Stall}, 32'h0);
        step();
        check("add_aluop", {27'b0, ALUOp}, 32'h0);
        check("add_regs", {29'b0, RegWrite, RegDst, MemtoReg}, 32'h7);
        check("add_others", {28'b0, ALUSrc, MemRead, MemWrite, IllegalOp}, 32'h0);

        // Load-use hazard on rs, then rt, then $0 and a non-read field
        ExMemRead = 1'b1;
        ExRt      = 5'd5;
        drive(add_6_5_7, 1'b1);
        check("lu_rs_stall", {31'b0, Stall}, 32'h1);
        step();
        check("lu_bubble", all_ctrl(), 32'h0);
        ExRt = 5'd7; #1;
        check("lu_rt_stall", {31'b0, Stall}, 32'h1);
        ExRt = 5'd0; #1;
        check("lu_zero_nostall", {31'b0, Stall}, 32'h0);
        step();
        check("lu_zero_latched", {31'b0, RegWrite}, 32'h1);
        ExRt = 5'd6; #1;
        check("lu_rd_nostall", {31'b0, Stall}, 32'h0);
        ExMemRead = 1'b0;
        ExRt      = 5'd0;

        // Multiply interlock: mult then mflo
        drive(mult_1_2, 1'b1);
        check("mult_nostall", {31'b0, Stall}, 32'h0);
        step();
        check("mult_hilo_wr", {30'b0, Hi_write, Lo_write}, 32'h3);
        check("mult_aluop", {27'b0, ALUOp}, 32'h0E);
        drive(mflo_4, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("mflo_busy_%0d", i), {31'b0, MulBusy}, 32'h1);
            check($sformatf("mflo_stall_%0d", i), {31'b0, Stall}, 32'h1);
            step();
            check($sformatf("mflo_bubble_%0d", i), all_ctrl(), 32'h0);
        end
        check("mflo_busy_last", {31'b0, MulBusy}, 32'h1);
        check("mflo_release", {31'b0, Stall}, 32'h0);
        step();
        check("mflo_aluop", {27'b0, ALUOp}, 32'h15);
        check("mflo_busy_fell", {31'b0, MulBusy}, 32'h0);
        check("mflo_regwrite", {31'b0, RegWrite}, 32'h1);

        // mul with GPR destination: dependent stalls, independent does not
        drive(mul_5_1_2, 1'b1);
        step();
        check("mul_aluop", {27'b0, ALUOp}, 32'h12);
        drive(add_6_5_7, 1'b1);
        check("mul_dep_stall", {31'b0, Stall}, 32'h1);
        drive(add_3_1_2, 1'b1);
        check("mul_indep_nostall", {31'b0, Stall}, 32'h0);
        step();
        drive(32'h0, 1'b0);
        for (int i = 0; i < 3; i++) step();
        check("mul_drained", {31'b0, MulBusy}, 32'h0);

        // Flush with sw in ID: two flush bubbles, then sw
        BranchTaken = 1'b1;
        drive(sw_2_1, 1'b1);
        step();
        BranchTaken = 1'b0;
        check("flush1", {30'b0, ContFlush, MemWrite}, 32'h2);
        step();
        check("flush2", {30'b0, ContFlush, MemWrite}, 32'h2);
        step();
        check("flush_done_sw", {30'b0, ContFlush, MemWrite}, 32'h1);

        // Branch together with load-use: flush wins; mult during flush is discarded
        ExMemRead   = 1'b1;
        ExRt        = 5'd5;
        BranchTaken = 1'b1;
        drive(add_6_5_7, 1'b1);
        check("simul_nostall", {31'b0, Stall}, 32'h0);
        step();
        check("simul_flush", {31'b0, ContFlush}, 32'h1);
        BranchTaken = 1'b0;
        ExMemRead   = 1'b0;
        ExRt        = 5'd0;
        drive(mult_1_2, 1'b1);
        step();
        check("flush_mult_flushed", {31'b0, ContFlush}, 32'h1);
        check("flush_mult_nobusy", {31'b0, MulBusy}, 32'h0);
        drive(32'h0, 1'b0);
        step();
        check("flush_mult_end", {30'b0, ContFlush, MulBusy}, 32'h0);

        // BranchTaken during a flush restarts the count
        BranchTaken = 1'b1;
        step();
        step();
        BranchTaken = 1'b0;
        step();
        check("restart_third_bubble", {31'b0, ContFlush}, 32'h1);
        step();
        check("restart_done", {31'b0, ContFlush}, 32'h0);

        // Illegal opcode, valid and invalid
        drive(ill_ins, 1'b1);
        step();
        check("illegal_valid", all_ctrl(), 32'h1000);
        drive(ill_ins, 1'b0);
        step();
        check("illegal_invalid", all_ctrl(), 32'h0);

        // jal and lb
        drive(jal_ins, 1'b1);
        step();
        check("jal_flags", {29'b0, Branch, RegWrite, branchSel}, 32'h7);
        check("jal_jsel", {30'b0, JSel}, 32'h1);
        check("jal_brres", {29'b0, branchRes}, 32'h6);
        drive(lb_2_1, 1'b1);
        step();
        check("lb_dmsel", {30'b0, DM_Sel}, 32'h2);
        check("lb_flags", {28'b0, ALUSrc, RegWrite, MemRead, MemtoReg}, 32'hE);

        // Reset mid-multiply clears everything asynchronously
        drive(mult_1_2, 1'b1);
        step();
        check("pre_reset_busy", {31'b0, MulBusy}, 32'h1);
        drive(32'h0, 1'b0);
        #2;
        Rst = 1'b0;
        #1;
        check("async_reset_busy", {31'b0, MulBusy}, 32'h0);
        check("async_reset_ctrl", all_ctrl(), 32'h0);
        @(negedge Clk);
        Rst = 1'b1;
        drive(add_3_1_2, 1'b1);
        step();
        check("post_reset_add", {24'b0, ALUOp, RegWrite, RegDst, MemtoReg}, 32'h07);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
